// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the data memory.
// slave = arbiter side; master = requester/memory side.
interface dmem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_adr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic        cpu_stall;

    logic        ext_req;
    logic        ext_we;
    logic [31:0] ext_adr;
    logic [31:0] ext_wdata;
    logic [31:0] ext_rdata;
    logic        ext_done;

    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic        mem_mwr;
    logic        mem_moe;
    logic [31:0] mem_rd;

    modport slave (
        input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
        output cpu_rdata, cpu_done, cpu_stall,
        input  ext_req, ext_we, ext_adr, ext_wdata,
        output ext_rdata, ext_done,
        output mem_adr, mem_wdata, mem_mwr, mem_moe,
        input  mem_rd
    );

    modport master (
        output cpu_req, cpu_we, cpu_adr, cpu_wdata,
        input  cpu_rdata, cpu_done, cpu_stall,
        output ext_req, ext_we, ext_adr, ext_wdata,
        input  ext_rdata, ext_done,
        input  mem_adr, mem_wdata, mem_mwr, mem_moe,
        output mem_rd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: alternating-priority grant,
// fixed MEM_LAT access sequencing, registered memory controls and per-requester read data.
module dmem_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t      state_r,      state_s;
    owner_t      owner_r,      owner_s;
    owner_t      last_owner_r, last_owner_s;
    logic [3:0]  cnt_r,        cnt_s;
    logic        we_r,         we_s;
    logic [31:0] adr_r,        adr_s;
    logic [31:0] wdata_r,      wdata_s;
    logic        mwr_r,        mwr_s;
    logic        moe_r,        moe_s;
    logic        cpu_done_r,   cpu_done_s;
    logic        ext_done_r,   ext_done_s;
    logic [31:0] cpu_rdata_r,  cpu_rdata_s;
    logic [31:0] ext_rdata_r,  ext_rdata_s;
    logic        grant_cpu_s;

    // next-state and next-output logic; memory controls are prepared one cycle ahead
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        last_owner_s = last_owner_r;
        cnt_s        = cnt_r;
        we_s         = we_r;
        adr_s        = adr_r;
        wdata_s      = wdata_r;
        mwr_s        = mwr_r;
        moe_s        = moe_r;
        cpu_done_s   = 1'b0;
        ext_done_s   = 1'b0;
        cpu_rdata_s  = cpu_rdata_r;
        ext_rdata_s  = ext_rdata_r;
        // on a tie the requester that did not own the last access wins
        grant_cpu_s  = bus.cpu_req & (~bus.ext_req | (last_owner_r == OWN_EXT));

        case (state_r)
            IDLE: begin
                if (grant_cpu_s) begin
                    owner_s      = OWN_CPU;
                    last_owner_s = OWN_CPU;
                    we_s         = bus.cpu_we;
                    adr_s        = bus.cpu_adr;
                    wdata_s      = bus.cpu_wdata;
                    mwr_s        = bus.cpu_we;
                    moe_s        = ~bus.cpu_we;
                    cnt_s        = CNT_INIT;
                    state_s      = BUSY;
                end else if (bus.ext_req) begin
                    owner_s      = OWN_EXT;
                    last_owner_s = OWN_EXT;
                    we_s         = bus.ext_we;
                    adr_s        = bus.ext_adr;
                    wdata_s      = bus.ext_wdata;
                    mwr_s        = bus.ext_we;
                    moe_s        = ~bus.ext_we;
                    cnt_s        = CNT_INIT;
                    state_s      = BUSY;
                end else begin
                    state_s      = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == 4'd0) begin
                    mwr_s   = 1'b0;
                    moe_s   = 1'b0;
                    state_s = DONE;
                    if (owner_r == OWN_CPU) begin
                        cpu_done_s = 1'b1;
                        if (!we_r) begin
                            cpu_rdata_s = bus.mem_rd;
                        end else begin
                            cpu_rdata_s = cpu_rdata_r;
                        end
                    end else begin
                        ext_done_s = 1'b1;
                        if (!we_r) begin
                            ext_rdata_s = bus.mem_rd;
                        end else begin
                            ext_rdata_s = ext_rdata_r;
                        end
                    end
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                mwr_s   = 1'b0;
                moe_s   = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // state register and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            owner_r      <= OWN_CPU;
            last_owner_r <= OWN_EXT;
            cnt_r        <= 4'd0;
            we_r         <= 1'b0;
            adr_r        <= 32'h0000_0000;
            wdata_r      <= 32'h0000_0000;
            mwr_r        <= 1'b0;
            moe_r        <= 1'b0;
            cpu_done_r   <= 1'b0;
            ext_done_r   <= 1'b0;
            cpu_rdata_r  <= 32'h0000_0000;
            ext_rdata_r  <= 32'h0000_0000;
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            last_owner_r <= last_owner_s;
            cnt_r        <= cnt_s;
            we_r         <= we_s;
            adr_r        <= adr_s;
            wdata_r      <= wdata_s;
            mwr_r        <= mwr_s;
            moe_r        <= moe_s;
            cpu_done_r   <= cpu_done_s;
            ext_done_r   <= ext_done_s;
            cpu_rdata_r  <= cpu_rdata_s;
            ext_rdata_r  <= ext_rdata_s;
        end
    end

    assign bus.mem_adr   = adr_r;
    assign bus.mem_wdata = wdata_r;
    assign bus.mem_mwr   = mwr_r;
    assign bus.mem_moe   = moe_r;
    assign bus.cpu_done  = cpu_done_r;
    assign bus.ext_done  = ext_done_r;
    assign bus.cpu_rdata = cpu_rdata_r;
    assign bus.ext_rdata = ext_rdata_r;
    // the processor pc freezes from the request until the completion pulse
    assign bus.cpu_stall = bus.cpu_req & ~cpu_done_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one MEM_LAT=2 and one MEM_LAT=1 instance, each with a
// small word-addressed memory model; expected values are hand-derived per cycle.
module tb_dmem_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    dmem_arbiter_if bus2 ();
    dmem_arbiter_if bus1 ();

    dmem_arbiter #(.MEM_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    dmem_arbiter #(.MEM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic [31:0] mem2 [0:63];
    logic [31:0] mem1 [0:63];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory models: preload during reset, write on mem_mwr
    always_ff @(posedge clk) begin
        if (rst) begin
            mem2[9] <= 32'hCAFE_F00D;
            mem1[1] <= 32'h0000_0044;
            mem1[2] <= 32'h0000_0088;
        end else begin
            if (bus2.mem_mwr) mem2[bus2.mem_adr[7:2]] <= bus2.mem_wdata;
            if (bus1.mem_mwr) mem1[bus1.mem_adr[7:2]] <= bus1.mem_wdata;
        end
    end

    assign bus2.mem_rd = mem2[bus2.mem_adr[7:2]];
    assign bus1.mem_rd = mem1[bus1.mem_adr[7:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " cpu_done"},  32'(bus2.cpu_done),  32'h0);
        chk({tag, " ext_done"},  32'(bus2.ext_done),  32'h0);
        chk({tag, " cpu_rdata"}, bus2.cpu_rdata,      32'h0);
        chk({tag, " ext_rdata"}, bus2.ext_rdata,      32'h0);
        chk({tag, " mwr"},       32'(bus2.mem_mwr),   32'h0);
        chk({tag, " moe"},       32'(bus2.mem_moe),   32'h0);
        chk({tag, " adr"},       bus2.mem_adr,        32'h0);
        chk({tag, " wdata"},     bus2.mem_wdata,      32'h0);
        chk({tag, " stall"},     32'(bus2.cpu_stall), 32'h0);
        chk({tag, " l1 done"},   32'({bus1.cpu_done, bus1.ext_done}), 32'h0);
        chk({tag, " l1 rdata"},  bus1.cpu_rdata | bus1.ext_rdata, 32'h0);
        chk({tag, " l1 mem"},    32'({bus1.mem_mwr, bus1.mem_moe, bus1.cpu_stall}), 32'h0);
        chk({tag, " l1 bus"},    bus1.mem_adr | bus1.mem_wdata, 32'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        bus2.cpu_req = 1'b0; bus2.cpu_we = 1'b0; bus2.cpu_adr = 32'h0; bus2.cpu_wdata = 32'h0;
        bus2.ext_req = 1'b0; bus2.ext_we = 1'b0; bus2.ext_adr = 32'h0; bus2.ext_wdata = 32'h0;
        bus1.cpu_req = 1'b0; bus1.cpu_we = 1'b0; bus1.cpu_adr = 32'h0; bus1.cpu_wdata = 32'h0;
        bus1.ext_req = 1'b0; bus1.ext_we = 1'b0; bus1.ext_adr = 32'h0; bus1.ext_wdata = 32'h0;

        // reset, then 5 idle cycles
        tick(); tick(); tick();
        chk_quiet("reset");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_quiet("idle");
        end

        // CPU write 0xDEADBEEF to 0x10 (cycle 0)
        bus2.cpu_req = 1'b1; bus2.cpu_we = 1'b1;
        bus2.cpu_adr = 32'h10; bus2.cpu_wdata = 32'hDEAD_BEEF;
        #1;
        chk("wr c0 stall", 32'(bus2.cpu_stall), 32'h1);
        chk("wr c0 mwr",   32'(bus2.mem_mwr),   32'h0);
        for (int c = 1; c <= 2; c++) begin
            tick();
            chk("wr busy mwr",   32'(bus2.mem_mwr),   32'h1);
            chk("wr busy moe",   32'(bus2.mem_moe),   32'h0);
            chk("wr busy adr",   bus2.mem_adr,        32'h10);
            chk("wr busy wdata", bus2.mem_wdata,      32'hDEAD_BEEF);
            chk("wr busy stall", 32'(bus2.cpu_stall), 32'h1);
            chk("wr busy done",  32'(bus2.cpu_done),  32'h0);
        end
        tick();
        chk("wr c3 done",  32'(bus2.cpu_done),  32'h1);
        chk("wr c3 stall", 32'(bus2.cpu_stall), 32'h0);
        chk("wr c3 mwr",   32'(bus2.mem_mwr),   32'h0);
        chk("wr c3 rdata", bus2.cpu_rdata,      32'h0);
        bus2.cpu_req = 1'b0;
        tick();
        chk("wr c4 done",  32'(bus2.cpu_done),  32'h0);

        // CPU read of 0x10
        bus2.cpu_req = 1'b1; bus2.cpu_we = 1'b0; bus2.cpu_wdata = 32'h0;
        for (int c = 1; c <= 2; c++) begin
            tick();
            chk("rd busy moe", 32'(bus2.mem_moe), 32'h1);
            chk("rd busy mwr", 32'(bus2.mem_mwr), 32'h0);
            chk("rd busy adr", bus2.mem_adr,      32'h10);
        end
        tick();
        chk("rd c3 done",  32'(bus2.cpu_done), 32'h1);
        chk("rd c3 rdata", bus2.cpu_rdata,     32'hDEAD_BEEF);
        chk("rd c3 moe",   32'(bus2.mem_moe),  32'h0);
        bus2.cpu_req = 1'b0;
        tick();
        chk("rd c4 rdata", bus2.cpu_rdata,     32'hDEAD_BEEF);
        chk("rd c4 done",  32'(bus2.cpu_done), 32'h0);

        // EXT write aborted by reset in its first BUSY cycle
        bus2.ext_req = 1'b1; bus2.ext_we = 1'b1;
        bus2.ext_adr = 32'h30; bus2.ext_wdata = 32'h1234_5678;
        tick();
        chk("abort c1 mwr", 32'(bus2.mem_mwr), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort c2 mwr",   32'(bus2.mem_mwr),  32'h0);
        chk("abort c2 done",  32'(bus2.ext_done), 32'h0);
        chk("abort c2 rdata", bus2.cpu_rdata,     32'h0);
        bus2.cpu_req = 1'b1; bus2.cpu_we = 1'b0; bus2.cpu_adr = 32'h10;
        tick();
        chk("abort c3 moe",  32'(bus2.mem_moe),  32'h1);
        chk("abort c3 adr",  bus2.mem_adr,       32'h10);
        chk("abort c3 done", 32'(bus2.ext_done), 32'h0);
        tick();
        tick();
        chk("abort c5 cpu_done", 32'(bus2.cpu_done), 32'h1);
        chk("abort c5 ext_done", 32'(bus2.ext_done), 32'h0);
        chk("abort c5 rdata",    bus2.cpu_rdata,     32'hDEAD_BEEF);
        bus2.cpu_req = 1'b0;
        bus2.ext_req = 1'b0;

        // both requesters held from reset: CPU writes 0x20, EXT reads 0x24
        rst = 1'b1;
        bus2.cpu_req = 1'b1; bus2.cpu_we = 1'b1;
        bus2.cpu_adr = 32'h20; bus2.cpu_wdata = 32'h1111_1111;
        bus2.ext_req = 1'b1; bus2.ext_we = 1'b0;
        bus2.ext_adr = 32'h24; bus2.ext_wdata = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            logic cpu_own;
            logic busy;
            tick();
            cpu_own = ((c / 4) % 2) == 0;
            busy    = (c % 4 == 1) || (c % 4 == 2);
            chk($sformatf("tie c%0d mwr", c),      32'(bus2.mem_mwr),  32'(busy & cpu_own));
            chk($sformatf("tie c%0d moe", c),      32'(bus2.mem_moe),  32'(busy & ~cpu_own));
            chk($sformatf("tie c%0d cpu_done", c), 32'(bus2.cpu_done), 32'((c % 4 == 3) & cpu_own));
            chk($sformatf("tie c%0d ext_done", c), 32'(bus2.ext_done), 32'((c % 4 == 3) & ~cpu_own));
            if (busy) begin
                chk($sformatf("tie c%0d adr", c), bus2.mem_adr, cpu_own ? 32'h20 : 32'h24);
            end
            if (c == 6) chk("tie c6 ext_rdata", bus2.ext_rdata, 32'h0);
            if (c == 7 || c == 15) chk($sformatf("tie c%0d ext_rdata", c), bus2.ext_rdata, 32'hCAFE_F00D);
        end
        bus2.cpu_req = 1'b0;
        bus2.ext_req = 1'b0;
        tick();
        chk("tie end mwr", 32'(bus2.mem_mwr), 32'h0);
        chk("tie end moe", 32'(bus2.mem_moe), 32'h0);

        // MEM_LAT=1: back-to-back CPU reads of 0x4 then 0x8
        bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b0; bus1.cpu_adr = 32'h4;
        tick();
        chk("l1 c1 moe",   32'(bus1.mem_moe),  32'h1);
        chk("l1 c1 adr",   bus1.mem_adr,       32'h4);
        chk("l1 c1 done",  32'(bus1.cpu_done), 32'h0);
        tick();
        chk("l1 c2 done",  32'(bus1.cpu_done), 32'h1);
        chk("l1 c2 rdata", bus1.cpu_rdata,     32'h44);
        chk("l1 c2 moe",   32'(bus1.mem_moe),  32'h0);
        bus1.cpu_adr = 32'h8;
        tick();
        chk("l1 c3 moe",   32'(bus1.mem_moe),  32'h0);
        chk("l1 c3 done",  32'(bus1.cpu_done), 32'h0);
        chk("l1 c3 rdata", bus1.cpu_rdata,     32'h44);
        tick();
        chk("l1 c4 moe",   32'(bus1.mem_moe),  32'h1);
        chk("l1 c4 adr",   bus1.mem_adr,       32'h8);
        tick();
        chk("l1 c5 done",  32'(bus1.cpu_done), 32'h1);
        chk("l1 c5 rdata", bus1.cpu_rdata,     32'h88);
        chk("l1 c5 moe",   32'(bus1.mem_moe),  32'h0);
        bus1.cpu_req = 1'b0;
        tick();
        chk("l1 c6 moe",   32'(bus1.mem_moe),  32'h0);
        chk("l1 c6 done",  32'(bus1.cpu_done), 32'h0);
        chk("l1 c6 rdata", bus1.cpu_rdata,     32'h88);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters:
  - the processor load/store path, port `cpu_*`;
  - an external debug/DMA master, port `ext_*`.
- Sits between the processor's ALU-address/rd2 outputs and the data memory. Drives the memory's `adr`, write data, `mwr` and `moe`.
- Sequences each access over a fixed memory latency.
- Arbitrates fairly with alternating priority and gives the processor a stall signal.

Parameters:
- MEM_LAT, 2: cycles a memory access occupies (memory read data valid at the end of the last one); legal range 1..16.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  processor access request; held until cpu_done
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_adr  in  32  byte address; stable while cpu_req
- cpu_wdata  in  32  write data; stable while cpu_req
- cpu_rdata  out  32  read data, registered, valid from cpu_done onward
- cpu_done  out  1  one-cycle completion pulse
- cpu_stall  out  1  cpu_req & ~cpu_done (combinational); freezes the processor pc
- ext_req, ext_we, ext_adr, ext_wdata, ext_rdata, ext_done: same meaning and widths for the external master
- mem_adr  out  32  address to data memory
- mem_wdata  out  32  write data to data memory
- mem_mwr  out  1  memory write enable
- mem_moe  out  1  memory output enable (read)
- mem_rd  in  32  memory read data

Behaviour:
- Clock and reset: one clock, `clk`; `rst` is synchronous and active-high.
- Reset values:
  - state = IDLE;
  - cpu_done = ext_done = 0, cpu_rdata = ext_rdata = 0;
  - mem_mwr = mem_moe = 0, mem_adr = mem_wdata = 0;
  - last_owner = EXT, so the CPU wins the first tie;
  - cnt = 0.
- States:
  - IDLE:
    - Samples requests every cycle.
    - cpu_req only: grant CPU. ext_req only: grant EXT. Both: grant the requester that is not last_owner.
    - On grant: latch the owner's adr, wdata and we into internal registers; set owner and last_owner; set cnt = MEM_LAT-1; go to BUSY.
    - No request: stay in IDLE.
  - BUSY:
    - mem_adr and mem_wdata come from the latched registers.
    - Write: mem_mwr = 1 for every BUSY cycle. Read: mem_moe = 1 for every BUSY cycle.
    - cnt decrements each cycle.
    - When cnt == 0: on a read, capture mem_rd into the owner's rdata register at that edge; go to DONE.
  - DONE:
    - Owner's done = 1 for exactly this cycle; mem_mwr = mem_moe = 0; then go to IDLE.
- Timing and latency:
  - Request seen in IDLE at cycle 0, BUSY cycles 1..MEM_LAT, done in cycle MEM_LAT+1, IDLE in cycle MEM_LAT+2.
  - Minimum issue spacing is MEM_LAT+2 cycles.
- Handshake:
  - A requester keeps req and its qualifiers stable until it samples done=1.
  - It must drop req in the cycle after done, or keep req high only to request a new access. Req high in IDLE is always a new access.
  - Changes to a requester's inputs after grant have no effect on the transfer in flight.
  - The non-owner's req is ignored until IDLE; the non-owner's done stays 0.
- Data retention: rdata registers hold their value until the next read completion for that requester. Write completions do not modify rdata.
- Fairness: with both requesters held continuously, grants strictly alternate, so no starvation.
- Reset mid-operation: the access is aborted with no done pulse. mem_mwr and mem_moe are 0 from the cycle after the reset edge. rdata registers clear.
- mem_adr is passed through unmodified; alignment is the requester's responsibility.
- With MEM_LAT = 1: BUSY lasts one cycle, done appears in cycle 2.

Test Plan:
- Reset, then idle for 5 cycles:
  - all outputs stay 0;
  - cpu_stall follows cpu_req;
  - no mem_mwr or mem_moe activity.
- CPU write, MEM_LAT=2: cpu_req=1, cpu_we=1, adr=0x10, wdata=0xDEADBEEF at cycle 0.
  - mem_mwr=1 with mem_adr=0x10 and mem_wdata=0xDEADBEEF in cycles 1-2.
  - cpu_done=1 in cycle 3.
  - cpu_stall=1 in cycles 0-2 and 0 in cycle 3.
- CPU read of 0x10 after that write (memory model returns 0xDEADBEEF):
  - mem_moe=1 in cycles 1-2;
  - cpu_done=1 in cycle 3 with cpu_rdata=0xDEADBEEF;
  - cpu_rdata keeps that value after cpu_req drops.
- Simultaneous requests: cpu_req and ext_req both held continuously from reset.
  - Grant order is CPU, EXT, CPU, EXT.
  - done pulses at cycles 3, 7, 11, 15 (MEM_LAT=2).
  - The ext read data is unaffected by the CPU writes' wdata.
- Reset mid-access: start an EXT write, assert rst in BUSY cycle 1.
  - No ext_done pulse;
  - mem_mwr=0 the following cycle;
  - state returns to IDLE; a CPU request then wins the first tie.
- MEM_LAT=1 build with back-to-back CPU reads of 0x4 and 0x8:
  - done at cycles 2 and 5;
  - cpu_rdata updates at each done;
  - mem_moe high for exactly one cycle per access.
